spi_controller: RTL and testbench

- Single-byte (DATA_WIDTH) full-duplex SPI master with a programmable SCLK divider.
- On a start strobe it asserts CS and shifts i_data_in out on MOSI, MSB first, while capturing MISO into o_data_out.
- It pulses o_done when the frame completes.
- It sits between the encryption engine's control logic and an external SPI slave.

---
 rtl/spi_controller_pkg.sv | 8 +
 rtl/spi_controller_if.sv | 22 ++
 rtl/spi_clk_gen.sv | 35 +++
 rtl/spi_controller.sv | 99 +++++++++
 tb/tb_spi_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/spi_controller_pkg.sv
// spi_controller_pkg: shared FSM states, divider width and bit-counter sizing for the SPI master.
package spi_controller_pkg;
  localparam int DIV_W = 8;
  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_e;
  function automatic int bit_cnt_w(input int dw);
    return $clog2(dw) + 1;
  endfunction
endpackage

// File: rtl/spi_controller_if.sv
// spi_controller_if: control-side and SPI pin bundle; slave modport is the controller, master the surrounding logic.
interface spi_controller_if #(parameter int DATA_WIDTH = 8);
  import spi_controller_pkg::*;
  logic [DATA_WIDTH-1:0] i_data_in;
  logic [DATA_WIDTH-1:0] o_data_out;
  logic [DIV_W-1:0]      i_clk_div;
  logic i_start;
  logic o_done;
  logic o_busy;
  logic o_spi_mosi;
  logic i_spi_miso;
  logic o_spi_clk;
  logic o_spi_cs;
  modport master (
    output i_data_in, i_start, i_clk_div, i_spi_miso,
    input  o_data_out, o_done, o_busy, o_spi_mosi, o_spi_clk, o_spi_cs
  );
  modport slave (
    input  i_data_in, i_start, i_clk_div, i_spi_miso,
    output o_data_out, o_done, o_busy, o_spi_mosi, o_spi_clk, o_spi_cs
  );
endinterface

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: half-period counter producing tick plus leading/trailing strobes and the registered SCLK.
module spi_clk_gen
  import spi_controller_pkg::*;
#(
  parameter bit CPOL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             active,
  input  logic             sclk_en,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             lead,
  output logic             trail,
  output logic             sclk
);
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] cnt;
  assign tick  = active && (cnt == half - 1'b1);
  assign lead  = tick && sclk_en && (sclk == CPOL);
  assign trail = tick && sclk_en && (sclk != CPOL);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      half <= '0;
      cnt  <= '0;
      sclk <= CPOL;
    end else if (load) begin
      half <= (div == '0) ? DIV_W'(1) : div;
      cnt  <= '0;
    end else if (active) begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (lead || trail) sclk <= ~sclk;
    end
endmodule

// File: rtl/spi_controller.sv
// spi_controller: single-frame full-duplex SPI master, MSB first by default.
// Define SPI_LSB_FIRST_EN to shift TX and RX LSB first.
module spi_controller
  import spi_controller_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input logic         i_clk,
  input logic         i_rst,
  spi_controller_if.slave bus
);
  localparam int BW = bit_cnt_w(DATA_WIDTH);
`ifdef SPI_LSB_FIRST_EN
  function automatic logic head(input logic [DATA_WIDTH-1:0] v);
    return v[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] drop(input logic [DATA_WIDTH-1:0] v);
    return v >> 1;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] push(input logic [DATA_WIDTH-1:0] v, input logic b);
    return {b, v[DATA_WIDTH-1:1]};
  endfunction
`else
  function automatic logic head(input logic [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] drop(input logic [DATA_WIDTH-1:0] v);
    return v << 1;
  endfunction
  function automatic logic [DATA_WIDTH-1:0] push(input logic [DATA_WIDTH-1:0] v, input logic b);
    return {v[DATA_WIDTH-2:0], b};
  endfunction
`endif
  state_e                state;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [BW-1:0]         bit_cnt;
  logic tick, lead, trail, last_bit, shift_tx;
  assign last_bit = bit_cnt == BW'(DATA_WIDTH - 1);
  // CPHA=0 preloads bit 0 of the frame at start, so the final trailing edge must not advance MOSI
  assign shift_tx = CPHA ? lead : (trail && !last_bit);
  spi_clk_gen #(.CPOL(CPOL)) u_clk_gen (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .load    (state == IDLE && bus.i_start),
    .active  (state == SETUP || state == XFER || state == HOLD),
    .sclk_en (state == SETUP || state == XFER),
    .div     (bus.i_clk_div),
    .tick    (tick),
    .lead    (lead),
    .trail   (trail),
    .sclk    (bus.o_spi_clk)
  );
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      state          <= IDLE;
      tx_sr          <= '0;
      rx_sr          <= '0;
      bit_cnt        <= '0;
      bus.o_spi_cs   <= 1'b1;
      bus.o_spi_mosi <= 1'b0;
      bus.o_data_out <= '0;
      bus.o_done     <= 1'b0;
      bus.o_busy     <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      if (shift_tx) begin
        bus.o_spi_mosi <= head(tx_sr);
        tx_sr          <= drop(tx_sr);
      end
      if (trail) begin
        rx_sr   <= push(rx_sr, bus.i_spi_miso);
        bit_cnt <= bit_cnt + 1'b1;
      end
      case (state)
        IDLE: if (bus.i_start) begin
          state        <= SETUP;
          bus.o_busy   <= 1'b1;
          bus.o_spi_cs <= 1'b0;
          bit_cnt      <= '0;
          rx_sr        <= '0;
          tx_sr        <= CPHA ? bus.i_data_in : drop(bus.i_data_in);
          if (!CPHA) bus.o_spi_mosi <= head(bus.i_data_in);
        end
        SETUP: if (tick) state <= XFER;
        XFER:  if (trail && last_bit) state <= HOLD;
        HOLD: if (tick) begin
          state          <= DONE;
          bus.o_spi_cs   <= 1'b1;
          bus.o_done     <= 1'b1;
          bus.o_busy     <= 1'b0;
          bus.o_data_out <= rx_sr;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_controller.sv
// tb_spi_controller: vector-table, corner-sequence and random frames checked against a bit-order model of SPI mode 0.
module tb_spi_controller;
  localparam int DW = 8;
  localparam bit CPOL = 1'b0;
  localparam bit CPHA = 1'b0;
  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] div;
    string      name;
  } vec_t;
  logic tb_spi_clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 tb_spi_clk = ~tb_spi_clk;
  spi_controller_if #(.DATA_WIDTH(DW)) bus ();
  spi_controller #(.DATA_WIDTH(DW), .CPOL(CPOL), .CPHA(CPHA)) dut (
    .i_clk (tb_spi_clk),
    .i_rst (rst_n),
    .bus   (bus)
  );
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cnt = 0;
  int busy_viol = 0;
  int slave_idx = 0;
  int done_base = 0;
  int viol_base = 0;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] done_data = '0;
  logic sclk_prev = CPOL;
  logic cs_prev = 1'b1;
  logic mosi_q[$];
  int   rise_q[$];
  function automatic int ord(input int k);
`ifdef SPI_LSB_FIRST_EN
    return k;
`else
    return DW - 1 - k;
`endif
  endfunction
  // Slave and monitor: SPI slave that updates MISO on each leading SCLK edge, and logs MOSI there
  always @(negedge tb_spi_clk) begin
    cyc++;
    if (cs_prev && !bus.o_spi_cs) begin
      mosi_q.delete();
      rise_q.delete();
      slave_idx = 0;
    end
    if (bus.o_spi_cs) bus.i_spi_miso = 1'b0;
    else if (bus.o_spi_clk != CPOL && sclk_prev == CPOL) begin
      mosi_q.push_back(bus.o_spi_mosi);
      rise_q.push_back(cyc);
      bus.i_spi_miso = (slave_idx < DW) ? slave_word[ord(slave_idx)] : 1'b0;
      slave_idx++;
    end
    if (bus.o_done) begin
      done_cnt++;
      done_data = bus.o_data_out;
    end
    if (!bus.o_spi_cs && !bus.o_busy) busy_viol++;
    sclk_prev = bus.o_spi_clk;
    cs_prev   = bus.o_spi_cs;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  task automatic start_frame(input logic [7:0] tx, input logic [7:0] rx, input logic [7:0] div);
    @(negedge tb_spi_clk);
    done_base       = done_cnt;
    viol_base       = busy_viol;
    slave_word      = rx;
    bus.i_data_in   = tx;
    bus.i_clk_div   = div;
    bus.i_start     = 1'b1;
    @(negedge tb_spi_clk);
    bus.i_start     = 1'b0;
    bus.i_data_in   = ~tx;
    bus.i_clk_div   = 8'd7;
  endtask
  task automatic finish_frame(input logic [7:0] tx, input logic [7:0] rx, input logic [7:0] div,
                              input string tag);
    int h, budget, n, bad;
    h      = (div == 0) ? 1 : int'(div);
    budget = (2 * DW + 4) * 2 * h + 40;
    n      = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge tb_spi_clk);
      n++;
    end
    @(negedge tb_spi_clk);
    #1;
    check({tag, " done_pulses"}, done_cnt - done_base, 1);
    check({tag, " data_out"}, done_data, rx);
    check({tag, " sclk_leading_edges"}, rise_q.size(), DW);
    bad = 0;
    for (int k = 0; k < DW; k++)
      if (k >= mosi_q.size() || mosi_q[k] !== tx[ord(k)]) bad++;
    check({tag, " mosi_bit_errors"}, bad, 0);
    bad = 0;
    for (int k = 1; k < rise_q.size(); k++)
      if (rise_q[k] - rise_q[k-1] != 2 * h) bad++;
    check({tag, " sclk_period_errors"}, bad, 0);
    check({tag, " cs_after"}, bus.o_spi_cs, 1);
    check({tag, " busy_after"}, bus.o_busy, 0);
    check({tag, " busy_gaps"}, busy_viol - viol_base, 0);
  endtask
  vec_t vecs[7];
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n, d;
    logic [7:0] rtx, rrx, rdiv;
    bus.i_start   = 1'b0;
    bus.i_data_in = '0;
    bus.i_clk_div = 8'd4;
    vecs[0] = '{8'hA5, 8'h5A, 8'd4,   "basic"};
    vecs[1] = '{8'h55, 8'hAA, 8'd4,   "b2b0"};
    vecs[2] = '{8'h33, 8'hCC, 8'd4,   "b2b1"};
    vecs[3] = '{8'h0F, 8'hF0, 8'd4,   "b2b2"};
    vecs[4] = '{8'hA5, 8'h5A, 8'd1,   "div1"};
    vecs[5] = '{8'hA5, 8'h5A, 8'd0,   "div0"};
    vecs[6] = '{8'h3C, 8'hC3, 8'd255, "div255"};
    repeat (2) @(negedge tb_spi_clk);
    #1;
    check("rst cs", bus.o_spi_cs, 1);
    check("rst sclk", bus.o_spi_clk, CPOL);
    check("rst done", bus.o_done, 0);
    check("rst busy", bus.o_busy, 0);
    check("rst data_out", bus.o_data_out, 0);
    check("rst mosi", bus.o_spi_mosi, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge tb_spi_clk);
    #1;
    check("idle cs", bus.o_spi_cs, 1);
    check("idle busy", bus.o_busy, 0);
    check("idle sclk", bus.o_spi_clk, CPOL);
    check("idle done_cnt", done_cnt, 0);
    foreach (vecs[i]) begin
      start_frame(vecs[i].tx, vecs[i].rx, vecs[i].div);
      finish_frame(vecs[i].tx, vecs[i].rx, vecs[i].div, vecs[i].name);
      repeat (3) @(negedge tb_spi_clk);
    end
    start_frame(8'h96, 8'h69, 8'd3);
    repeat (20) @(negedge tb_spi_clk);
    #1;
    check("busy midframe", bus.o_busy, 1);
    bus.i_data_in = 8'h11;
    bus.i_clk_div = 8'd1;
    bus.i_start   = 1'b1;
    @(negedge tb_spi_clk);
    bus.i_start   = 1'b0;
    finish_frame(8'h96, 8'h69, 8'd3, "busy_ignore");
    d = done_cnt;
    repeat (12) @(negedge tb_spi_clk);
    #1;
    check("busy no_extra_frame cs", bus.o_spi_cs, 1);
    check("busy no_extra_done", done_cnt - d, 0);
    start_frame(8'hA5, 8'h5A, 8'd4);
    n = 0;
    while (rise_q.size() < 2 && n < 200) begin
      @(negedge tb_spi_clk);
      n++;
    end
    check("abort reached_3rd_edge", rise_q.size() >= 2, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort cs", bus.o_spi_cs, 1);
    check("abort sclk", bus.o_spi_clk, CPOL);
    check("abort done", bus.o_done, 0);
    check("abort busy", bus.o_busy, 0);
    check("abort data_out", bus.o_data_out, 0);
    d = done_cnt;
    repeat (3) @(negedge tb_spi_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge tb_spi_clk);
    check("abort no_done", done_cnt - d, 0);
    start_frame(8'hA5, 8'h5A, 8'd4);
    finish_frame(8'hA5, 8'h5A, 8'd4, "after_abort");
    for (int i = 0; i < 20; i++) begin
      rtx  = 8'($urandom);
      rrx  = 8'($urandom);
      rdiv = 8'($urandom_range(0, 5));
      start_frame(rtx, rrx, rdiv);
      finish_frame(rtx, rrx, rdiv, $sformatf("rand%0d", i));
      repeat ($urandom_range(0, 4)) @(negedge tb_spi_clk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
